mux_scanner: RTL and testbench

MUX_SCANNER -- requirements
Module: mux_scanner

---
 rtl/mux_scanner_pkg.sv | 19 +
 rtl/dwell_counter.sv | 40 ++++
 rtl/mux_scanner.sv | 103 ++++++++++
 tb/tb_mux_scanner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux_scanner_pkg.sv
// Shared types and helpers for the channel mux scanner.
// Holds the mode encoding and the select-width function.
package mux_scanner_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // At least one select bit, even for a two-channel mux.
    function automatic int selw(input int channels);
        return (channels > 2) ? $clog2(channels) : 1;
    endfunction

    function automatic int cntw(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled, tc at the last count.
// clear has priority over en; reset has priority over both.
module dwell_counter
    import mux_scanner_pkg::*;
#(
    parameter int DWELL = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = cntw(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scanner.sv
// Registered N-channel mux with manual select and timed auto-scan.
// Hold freezes channel, dwell and err but data keeps tracking.
module mux_scanner
    import mux_scanner_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 3,
    localparam int SELW     = selw(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          data_out,
    output logic [SELW-1:0]           ch_out,
    output logic                      valid,
    output logic                      step,
    output logic                      err
);

    localparam logic [SELW:0]   CH_LIM  = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS - 1);

    logic [SELW-1:0]  ch_q,   ch_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  cho_q;
    logic             valid_q;
    logic             step_q, step_d;
    logic             err_q,  err_d;

    logic             dw_clr;
    logic             dw_en;
    logic             dw_tc;
    logic             sel_ok;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clock (clock),
        .reset (reset),
        .clear (dw_clr),
        .en    (dw_en),
        .tc    (dw_tc)
    );

    assign sel_ok = ({1'b0, sel} < CH_LIM);

    always_comb begin
        ch_d   = ch_q;
        err_d  = err_q;
        step_d = 1'b0;
        dw_clr = 1'b0;
        dw_en  = 1'b0;
        if (!hold) begin
            if (mode_e'(mode) == MODE_SCAN) begin
                dw_en = 1'b1;
                if (dw_tc) begin
                    ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                    step_d = 1'b1;
                end
            end else begin
                dw_clr = 1'b1;
                if (sel_ok) begin
                    ch_d  = sel;
                    err_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // Load the slice picked by the next channel so data and index align.
    assign data_d = data_in[int'(ch_d)*WIDTH +: WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            ch_q    <= '0;
            data_q  <= '0;
            cho_q   <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ch_q    <= ch_d;
            data_q  <= data_d;
            cho_q   <= ch_d;
            valid_q <= 1'b1;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign data_out = data_q;
    assign ch_out   = cho_q;
    assign valid    = valid_q;
    assign step     = step_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner: a 4-channel and a 3-channel instance.
// Expected values are hand-computed per step.
module tb_mux_scanner;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] din_a;
    logic [1:0]  sel_a;
    logic        mode_a, hold_a;
    logic [3:0]  dout_a;
    logic [1:0]  ch_a;
    logic        valid_a, step_a, err_a;

    logic [11:0] din_b;
    logic [1:0]  sel_b;
    logic        mode_b, hold_b;
    logic [3:0]  dout_b;
    logic [1:0]  ch_b;
    logic        valid_b, step_b, err_b;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mux_scanner #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut_a (
        .clock    (clk),
        .reset    (reset),
        .data_in  (din_a),
        .sel      (sel_a),
        .mode     (mode_a),
        .hold     (hold_a),
        .data_out (dout_a),
        .ch_out   (ch_a),
        .valid    (valid_a),
        .step     (step_a),
        .err      (err_a)
    );

    mux_scanner #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) dut_b (
        .clock    (clk),
        .reset    (reset),
        .data_in  (din_b),
        .sel      (sel_b),
        .mode     (mode_b),
        .hold     (hold_b),
        .data_out (dout_b),
        .ch_out   (ch_b),
        .valid    (valid_b),
        .step     (step_b),
        .err      (err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] ch,
                         input logic [3:0] d, input logic st);
        chk({tag, ".ch"},   32'(ch_a),   32'(ch));
        chk({tag, ".data"}, 32'(dout_a), 32'(d));
        chk({tag, ".step"}, 32'(step_a), 32'(st));
    endtask

    // Scan-order channel sequence for dut_a after each edge, from ch 0 dcnt 0.
    logic [1:0] scan_ch [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    logic       scan_st [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    logic [3:0] val_a   [4]  = '{4'hA, 4'hB, 4'hC, 4'hD};

    initial begin
        reset  = 1'b1;
        din_a  = 16'hFFFF;
        din_b  = 12'hFFF;
        sel_a  = 2'd0;
        sel_b  = 2'd0;
        mode_a = 1'b0;
        mode_b = 1'b0;
        hold_a = 1'b0;
        hold_b = 1'b0;
        tick();
        tick();
        chk("rst.data",  32'(dout_a),  32'h0);
        chk("rst.ch",    32'(ch_a),    32'h0);
        chk("rst.valid", 32'(valid_a), 32'h0);
        chk("rst.err",   32'(err_a),   32'h0);
        chk("rst.step",  32'(step_a),  32'h0);

        reset = 1'b0;
        din_a = 16'hDCBA;
        din_b = 12'hCBA;
        tick();
        chk("rel.valid", 32'(valid_a), 32'h1);
        chk("rel.data",  32'(dout_a),  32'hA);

        sel_a = 2'd2;
        sel_b = 2'd1;
        tick();
        chk_a("man2", 2'd2, 4'hC, 1'b0);
        chk("man2.err", 32'(err_a), 32'h0);
        chk("b.sel1.ch", 32'(ch_b), 32'h1);

        sel_b = 2'd3;
        tick();
        chk("b.oor.err",  32'(err_b),  32'h1);
        chk("b.oor.ch",   32'(ch_b),   32'h1);
        chk("b.oor.data", 32'(dout_b), 32'hB);

        mode_b = 1'b1;
        tick();
        chk("b.scan.err", 32'(err_b), 32'h1);
        chk("b.scan.ch",  32'(ch_b),  32'h1);

        mode_b = 1'b0;
        sel_b  = 2'd0;
        tick();
        chk("b.sel0.err",  32'(err_b),  32'h0);
        chk("b.sel0.ch",   32'(ch_b),   32'h0);
        chk("b.sel0.data", 32'(dout_b), 32'hA);

        sel_a = 2'd0;
        tick();
        chk_a("man0", 2'd0, 4'hA, 1'b0);

        mode_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_a($sformatf("scan%0d", i), scan_ch[i],
                  val_a[scan_ch[i]], scan_st[i]);
        end

        // Walk to ch 2 with dcnt 1: 7 more edges.
        for (int i = 0; i < 7; i++) tick();
        chk_a("pre_hold", 2'd2, 4'hC, 1'b0);

        hold_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a($sformatf("hold%0d", i), 2'd2, 4'hC, 1'b0);
        end
        din_a  = 16'h9CBA;
        hold_a = 1'b0;
        tick();
        chk_a("rel1", 2'd2, 4'hC, 1'b0);
        tick();
        chk_a("rel2", 2'd3, 4'h9, 1'b1);
        din_a = 16'hDCBA;

        // ch3 dcnt0 -> ch1 dcnt0 takes 6 edges.
        for (int i = 0; i < 6; i++) tick();
        chk_a("at_ch1", 2'd1, 4'hB, 1'b1);
        din_a = 16'hDC5A;
        tick();
        chk_a("track", 2'd1, 4'h5, 1'b0);
        tick();
        chk_a("dcnt2", 2'd1, 4'h5, 1'b0);

        reset = 1'b1;
        tick();
        chk_a("midrst", 2'd0, 4'h0, 1'b0);
        chk("midrst.valid", 32'(valid_a), 32'h0);
        reset = 1'b0;
        tick();
        chk_a("restart0", 2'd0, 4'hA, 1'b0);
        chk("restart.valid", 32'(valid_a), 32'h1);
        tick();
        chk_a("restart1", 2'd0, 4'hA, 1'b0);
        tick();
        chk_a("restart2", 2'd1, 4'h5, 1'b1);

        mode_a = 1'b0;
        sel_a  = 2'd3;
        tick();
        chk_a("to_man", 2'd3, 4'hD, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
